// File: rtl/daisy_arb_pkg.sv
// Shared types and the rotating-start priority search used by the daisy-chain arbiter.
package daisy_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int MAX_N  = 32;
    localparam int MAX_IW = 5;

    typedef struct packed {
        logic              found;
        logic [MAX_IW-1:0] idx;
    } sel_t;

    // Search cand[0..n-1] starting at 'start' and wrapping back to 0.
    function automatic sel_t prio_select(input logic [MAX_N-1:0] cand,
                                         input int                n,
                                         input int                start);
        sel_t r;
        int   k;
        r = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n) begin
                k = start + i;
                if (k >= n) k = k - n;
                if (!r.found && cand[k[MAX_IW-1:0]]) begin
                    r.found = 1'b1;
                    r.idx   = k[MAX_IW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/daisy_chain_arbiter_select.sv
// Combinational N-wide priority chain with a programmable starting index.
import daisy_arb_pkg::*;

module arb_select #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  cand_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    sel_t sel;

    always_comb begin
        sel     = prio_select(MAX_N'(cand_i), N, int'(start_i));
        found_o = sel.found;
        idx_o   = IW'(sel.idx);
    end

endmodule

// File: rtl/daisy_chain_arbiter.sv
// Registered one-hot daisy-chain arbiter with fixed or round-robin priority,
// optional hold timeout, and cin/cout cascading between stages.
import daisy_arb_pkg::*;

module daisy_chain_arbiter #(
    parameter int N        = 4,
    parameter int ROTATE   = 0,
    parameter int MAX_HOLD = 0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 cin_i,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gnt_o,
    output logic                 gnt_valid_o,
    output logic [$clog2(N)-1:0] gnt_id_o,
    output logic                 cout_o
);

    localparam int IW = $clog2(N);
    localparam int CW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [IW-1:0] LAST     = IW'(N - 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          valid_q, valid_d;
    logic [IW-1:0] id_q, id_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] ptr_q, ptr_d;

    logic [N-1:0]  cand;
    logic [IW-1:0] start;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic          take;
    logic          drop;

    // The holder is masked out while granted; on release its req is already low anyway.
    always_comb begin
        cand  = (state_q == GRANT) ? (req_i & ~gnt_q) : req_i;
        start = '0;
        if (ROTATE != 0) begin
            start = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    arb_select #(.N(N)) u_select (
        .cand_i  (cand),
        .start_i (start),
        .found_o (sel_found),
        .idx_o   (sel_idx)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        take    = 1'b0;
        drop    = 1'b0;

        unique case (state_q)
            IDLE: begin
                take = cin_i && sel_found;
            end
            GRANT: begin
                if (!cin_i) begin
                    drop = 1'b1;
                end else if (!req_i[id_q]) begin
                    take = sel_found;
                    drop = !sel_found;
                end else if ((MAX_HOLD > 0) && (cnt_q == HOLD_MAX)) begin
                    if (sel_found) take = 1'b1;
                    else           cnt_d = CW'(1);
                end else if (cnt_q < HOLD_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                drop = 1'b1;
            end
        endcase

        if (take) begin
            state_d = GRANT;
            gnt_d   = N'(1) << sel_idx;
            valid_d = 1'b1;
            id_d    = sel_idx;
            cnt_d   = CW'(1);
            if (ROTATE != 0) ptr_d = sel_idx;
        end else if (drop) begin
            state_d = IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            id_d    = '0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            cnt_q   <= '0;
            ptr_q   <= LAST;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_valid_o = valid_q;
    assign gnt_id_o    = id_q;
    assign cout_o      = cin_i & ~(|req_i) & ~valid_q;

endmodule

// File: doc/daisy_chain_arbiter.md
# daisy_chain_arbiter

Parametrised, registered successor to the single-bit daisy-chain arbiter cell. It arbitrates N request lines with one-hot registered grants, and holds each grant until the requester releases it or an optional hold timeout expires. It supports fixed (chain-order) or round-robin priority. A chain-enable input and a carry output let several instances cascade into a wider expandable chain, as the single-bit cells did.

## Interface
- N, default 4: number of requesters, ≥2; index 0 is the head of the chain.
- ROTATE, default 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- MAX_HOLD, default 0: maximum grant cycles before forced re-arbitration; 0 = unlimited.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cin  in  1  chain enable from upstream stage or tie-high at head.
- req  in  N  request vector, level-sensitive.
- gnt  out  N  registered one-hot grant; all-zero when idle.
- gnt_valid  out  1  registered; equals |gnt.
- gnt_id  out  $clog2(N)  registered index of current holder; 0 when idle.
- cout  out  1  combinational carry to downstream stage: cin & ~|req & ~gnt_valid.

## Operation
- The FSM has two states, IDLE and GRANT. Reset places it in IDLE: gnt=0, gnt_valid=0, gnt_id=0, hold counter=0, rotate pointer ptr=N-1.
- **Winner selection.** Fixed mode: lowest set index of the candidate vector. Rotate mode: first set index searching from (ptr+1) mod N upward with wrap.
- **IDLE.**
  - If cin & |req: select a winner, go to GRANT, and set gnt[winner], gnt_id=winner, counter=1.
  - In rotate mode, ptr ← winner.
- **GRANT, holder id.** Conditions are evaluated in priority order:
  - cin=0: preemption by upstream. Go to IDLE with gnt cleared next edge; ptr unchanged.
  - req[id]=0: release.
    - If other requests are pending, arbitrate among them the same cycle (back-to-back, no bubble).
    - Otherwise go to IDLE.
  - MAX_HOLD>0 and counter==MAX_HOLD: timeout.
    - Arbitrate among req & ~(1<<id).
    - If that set is empty, the holder keeps the grant and counter ← 1.
  - Otherwise hold; counter saturates at MAX_HOLD.
- Any new grant loads counter ← 1.
- gnt is never multi-hot and never asserted for an index whose req was 0 at the selecting edge.
- cout is high only while this stage is enabled, idle and unrequested, so downstream stages see priority strictly below this one.

## Timing
- Latency is 1 cycle: req sampled high at edge k gives gnt high after edge k (visible cycle k+1).
- Release: req[id] low at edge k clears gnt[id] after edge k. Any next grant appears in the same cycle.
- Preemption: cin low at edge k means gnt=0 after edge k. cout follows cin combinationally with no register.
- Timeout: with MAX_HOLD=M, the holder owns gnt for exactly M cycles before a competing requester is granted.
- Reset asserted mid-grant clears all outputs immediately (asynchronous); the first grant after deassertion follows the normal 1-cycle latency.
- Simultaneous release by the holder and new requests resolves in one edge. Only req at the edge is considered.

## Structure
- Package daisy_arb_pkg holds:
  - the state enum typedef (IDLE, GRANT);
  - the function for priority select with a rotating start, taking the candidate vector and start index and returning an index plus a found flag.
- Sub-module arb_select: combinational N-wide priority chain built from the candidate vector and the rotate start. It is instantiated once, and the FSM and counter live in the top.

## Test plan
- Fixed, N=4, cin=1, req=4'b1010 → gnt=4'b0010, gnt_id=1 one cycle later; drop req[1] → gnt=4'b1000 next cycle with no idle cycle.
- Rotate, N=4, req held at 4'b1111 and each holder drops req for one cycle after grant → grant order 0,1,2,3,0.
- MAX_HOLD=3, req=4'b0011 held → gnt_id=0 for 3 cycles, then 1 for 3 cycles, then 0.
- MAX_HOLD=3, req=4'b0001 only → gnt stays 4'b0001 indefinitely.
- Preemption: holder id=2, drop cin → gnt=0 next cycle and cout=0 while req≠0. With req=0 and cin=1 → cout=1 and gnt=0.
- Reset: assert rst_n=0 mid-grant → gnt, gnt_valid and gnt_id go to 0 asynchronously. Release reset with req=4'b0100 → gnt=4'b0100 after one edge.
